instr_fetch_unit: RTL and testbench

// - MIPS fetch stage, directly upstream of decode (register file read + 16->32 sign extension of instr[15:0]).
// - Owns the PC and issues word fetches to instruction memory over a valid/ready request channel.
// - Buffers returned instructions in a DEPTH-entry in-order queue and presents {instr, pc+4} to decode with valid/ready.
// - Handles branch/jump redirect: flushes queued and in-flight fetches.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_queue.sv | 82 ++++++++
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS front end.
//   ADDR_W / INSTR_W : address and instruction widths
//   PC_STEP          : byte increment between sequential instruction words
//   fetch_state_t    : fetch FSM states
//   align_pc()       : forces a byte address onto a word boundary
package mips_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // Redirect targets may carry stray low bits; instruction words are 4-byte aligned.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & ~(ADDR_W'(3));
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
// In-order instruction buffer between the imem response port and decode.
// Entries are kept in registers so the head is visible the cycle after a push.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (entries read back as zero)
//   clear      : drop all entries; wins over push and pop
//   push       : write push_data at the tail (ignored when full)
//   push_data  : instruction word to store
//   pop        : retire the head entry (ignored when empty)
//   head       : entry at the head of the queue
//   count      : number of valid entries, 0..DEPTH
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;
  logic [W-1:0]  slot_q [DEPTH];

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !clear && !full;
  assign do_pop  = pop  && !clear && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // One register per slot; only the slot under the write pointer loads.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [W-1:0] data_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
        end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
          data_reg <= push_data;
        end
      end

      assign slot_q[gi] = data_reg;
    end
  endgenerate

  assign head  = slot_q[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// MIPS fetch stage: owns the PC, issues word fetches to instruction memory,
// buffers returned words in order and hands {instr, pc+4} to decode.
// Taken branches/jumps redirect the PC and flush queued and in-flight fetches.
//   clk             : clock, rising edge
//   rst_n           : asynchronous active-low reset
//   imem_req_valid  : fetch request valid
//   imem_req_ready  : imem accepts the request
//   imem_req_addr   : word-aligned fetch address
//   imem_rsp_valid  : response valid (in order, no backpressure)
//   imem_rsp_data   : fetched instruction word
//   redirect_valid  : taken branch/jump, single-cycle pulse
//   redirect_pc     : redirect target (low two bits ignored)
//   id_valid        : instruction available to decode
//   id_ready        : decode accepts
//   id_instr        : instruction at the queue head
//   id_pc_plus4     : address of the head instruction + 4
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] deliv_pc_reg, deliv_pc_next;
  logic [CW-1:0]     outstanding_reg, outstanding_next;
  logic [CW-1:0]     drop_cnt_reg, drop_cnt_next;

  logic [CW-1:0]      q_count;
  logic [INSTR_W-1:0] q_head;
  logic               q_push;
  logic               q_pop;
  logic               q_clear;

  logic [CW:0] credit_used;
  logic        req_fire;
  logic        dec_fire;
  logic        rsp_accept;
  logic        rsp_drop;

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (q_clear),
    .push      (q_push),
    .push_data (imem_rsp_data),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count)
  );

  // Credit: every request in flight already owns a queue slot, so the
  // queue can never be asked to take more than DEPTH words.
  assign credit_used    = {1'b0, outstanding_reg} + {1'b0, q_count};
  assign imem_req_valid = (state_reg == FETCH) && (credit_used < DEPTH_LIM) && !redirect_valid;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign id_valid = (q_count != '0);
  assign dec_fire = id_valid && id_ready;

  // A response nobody is waiting for is a protocol error and is ignored.
  assign rsp_accept = (state_reg == FETCH) && imem_rsp_valid && (outstanding_reg != '0);
  assign rsp_drop   = (state_reg == FLUSH) && imem_rsp_valid && (drop_cnt_reg != '0);

  assign imem_req_addr = fetch_pc_reg;
  assign id_instr      = q_head;
  assign id_pc_plus4   = deliv_pc_reg + PC_STEP;

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    deliv_pc_next    = deliv_pc_reg;
    outstanding_next = outstanding_reg;
    drop_cnt_next    = drop_cnt_reg;
    q_push           = 1'b0;
    q_pop            = 1'b0;
    q_clear          = 1'b0;

    if (state_reg == IDLE) begin
      state_next = FETCH;
    end else if (redirect_valid) begin
      // Everything queued or still in flight belongs to the wrong path.
      // In-flight words move from the outstanding count to the drop count.
      q_clear          = 1'b1;
      fetch_pc_next    = align_pc(redirect_pc);
      deliv_pc_next    = align_pc(redirect_pc);
      outstanding_next = '0;
      if (state_reg == FETCH) begin
        drop_cnt_next = outstanding_reg - CW'(rsp_accept);
      end else begin
        drop_cnt_next = drop_cnt_reg - CW'(rsp_drop);
      end
      state_next = (drop_cnt_next != '0) ? FLUSH : FETCH;
    end else if (state_reg == FETCH) begin
      q_push = rsp_accept;
      q_pop  = dec_fire;
      if (req_fire) fetch_pc_next = fetch_pc_reg + PC_STEP;
      if (dec_fire) deliv_pc_next = deliv_pc_reg + PC_STEP;
      outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_accept);
    end else begin
      // FLUSH: swallow stale responses until the last one has arrived.
      if (rsp_drop) drop_cnt_next = drop_cnt_reg - CW'(1);
      if (drop_cnt_next == '0) state_next = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      fetch_pc_reg    <= RESET_PC;
      deliv_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      deliv_pc_reg    <= deliv_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. dut0 (RESET_PC=0) is checked every
// cycle against a queue/counter model of the fetch rules; dut1
// (RESET_PC=FFFF_FFF8) covers PC wrap-around and a mid-stream reset pulse.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;
  localparam int S_IDLE  = 0;
  localparam int S_FETCH = 1;
  localparam int S_FLUSH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0 signals
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc_plus4;

  // dut1 signals
  logic        rst1_n;
  logic        imem1_req_valid, imem1_req_ready;
  logic [31:0] imem1_req_addr;
  logic        imem1_rsp_valid;
  logic [31:0] imem1_rsp_data;
  logic        redirect1_valid;
  logic [31:0] redirect1_pc;
  logic        id1_valid, id1_ready;
  logic [31:0] id1_instr, id1_pc_plus4;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4)
  );

  instr_fetch_unit #(.RESET_PC(RPC1), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst1_n),
    .imem_req_valid(imem1_req_valid), .imem_req_ready(imem1_req_ready), .imem_req_addr(imem1_req_addr),
    .imem_rsp_valid(imem1_rsp_valid), .imem_rsp_data(imem1_rsp_data),
    .redirect_valid(redirect1_valid), .redirect_pc(redirect1_pc),
    .id_valid(id1_valid), .id_ready(id1_ready), .id_instr(id1_instr), .id_pc_plus4(id1_pc_plus4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk0     = 1'b0;

  // stimulus knobs for dut0
  logic        s_req_ready, s_id_ready, s_redir;
  logic [31:0] s_rpc;

  // behavioural model of dut0: instruction count, in-flight words, words to drop, PCs
  int          m_st, m_cnt, m_out, m_drop;
  logic [31:0] m_fetch, m_deliv;

  // imem model for dut0: fixed latency, in order
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend_q[$];
  int    lat;

  // imem model for dut1: one-cycle latency
  logic        pend1_v;
  logic [31:0] pend1_a;

  // transaction logs
  logic [31:0] fire_log[$], fire_cyc[$], held_log[$], dlv_pc4[$], dlv_instr[$];
  logic [31:0] fire1_log[$], dlv1_pc4[$], dlv1_instr[$];
  int          first_valid_cyc;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] getq(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit req, input bit rsp);
    bit fire, pop, take_rsp;
    int d;
    fire = req && s_req_ready;
    pop  = (m_cnt != 0) && s_id_ready;
    if (m_st == S_IDLE) begin
      m_st = S_FETCH;
    end else if (s_redir) begin
      if (m_st == S_FETCH) d = m_out - ((rsp && m_out > 0) ? 1 : 0);
      else                 d = m_drop - ((rsp && m_drop > 0) ? 1 : 0);
      m_cnt   = 0;
      m_out   = 0;
      m_drop  = d;
      m_fetch = s_rpc & 32'hFFFF_FFFC;
      m_deliv = s_rpc & 32'hFFFF_FFFC;
      m_st    = (d > 0) ? S_FLUSH : S_FETCH;
    end else if (m_st == S_FETCH) begin
      take_rsp = rsp && (m_out > 0);
      if (take_rsp) begin m_cnt++; m_out--; end
      if (fire)     begin m_out++; m_fetch = m_fetch + 32'd4; end
      if (pop)      begin m_cnt--; m_deliv = m_deliv + 32'd4; end
    end else begin
      if (rsp && m_drop > 0) m_drop--;
      if (m_drop == 0) m_st = S_FETCH;
    end
  endtask

  // One clock cycle: drive at posedge+1, compare and log at negedge.
  task automatic cycle();
    bit          exp_rv, rsp_v;
    logic [31:0] rsp_a;
    imem_req_ready = s_req_ready;
    id_ready       = s_id_ready;
    redirect_valid = s_redir;
    redirect_pc    = s_rpc;
    rsp_v = 1'b0;
    rsp_a = '0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      rsp_v = 1'b1;
      rsp_a = pend_q[0].addr;
      void'(pend_q.pop_front());
    end
    imem_rsp_valid  = rsp_v;
    imem_rsp_data   = memfn(rsp_a);
    imem1_rsp_valid = pend1_v;
    imem1_rsp_data  = memfn(pend1_a);
    @(negedge clk);
    if (chk0) begin
      exp_rv = (m_st == S_FETCH) && (m_out + m_cnt < DEPTH) && !s_redir;
      check("req_valid",   32'(imem_req_valid), 32'(exp_rv));
      check("req_addr",    imem_req_addr, m_fetch);
      check("id_valid",    32'(id_valid), 32'(m_cnt != 0));
      check("id_pc_plus4", id_pc_plus4, m_deliv + 32'd4);
      if (m_cnt != 0) check("id_instr", id_instr, memfn(m_deliv));
      if (rsp_v && m_st != S_IDLE) check("rsp_expected", 32'((m_out + m_drop) != 0), 32'd1);
      if (imem_req_valid && imem_req_ready) begin
        fire_log.push_back(imem_req_addr);
        fire_cyc.push_back(32'(cyc));
        pend_q.push_back('{imem_req_addr, cyc + lat});
      end
      if (imem_req_valid && !imem_req_ready) held_log.push_back(imem_req_addr);
      if (id_valid && id_ready) begin
        dlv_pc4.push_back(id_pc_plus4);
        dlv_instr.push_back(id_instr);
      end
      if (id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      model_step(exp_rv, rsp_v);
    end
    if (rst1_n) begin
      pend1_v = imem1_req_valid && imem1_req_ready;
      pend1_a = imem1_req_addr;
      if (pend1_v) fire1_log.push_back(imem1_req_addr);
      if (id1_valid && id1_ready) begin
        dlv1_pc4.push_back(id1_pc_plus4);
        dlv1_instr.push_back(id1_instr);
      end
    end else begin
      pend1_v = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called at posedge+1; leaves dut0 in its first post-reset cycle (cycle 0).
  task automatic reset_dut0(input int latency);
    rst_n          = 1'b0;
    chk0           = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    s_req_ready    = 1'b1;
    s_id_ready     = 1'b1;
    s_redir        = 1'b0;
    s_rpc          = '0;
    m_st = S_IDLE; m_cnt = 0; m_out = 0; m_drop = 0;
    m_fetch = 32'h0; m_deliv = 32'h0;
    pend_q.delete();
    fire_log.delete(); fire_cyc.delete(); held_log.delete();
    dlv_pc4.delete(); dlv_instr.delete();
    first_valid_cyc = -1;
    lat = latency;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr",  imem_req_addr, 32'h0);
    check("rst_id_valid",  32'(id_valid), 32'd0);
    check("rst_id_instr",  id_instr, 32'h0);
    check("rst_pc_plus4",  id_pc_plus4, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk0  = 1'b1;
    cyc   = 0;
  endtask

  task automatic check_dut1_reset(input string tag);
    check({tag, "_req_valid"}, 32'(imem1_req_valid), 32'd0);
    check({tag, "_req_addr"},  imem1_req_addr, RPC1);
    check({tag, "_id_valid"},  32'(id1_valid), 32'd0);
    check({tag, "_id_instr"},  id1_instr, 32'h0);
    check({tag, "_pc_plus4"},  id1_pc_plus4, 32'hFFFF_FFFC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; rst1_n = 1'b1;
    imem_req_ready = 1'b1; id_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem1_req_ready = 1'b1; id1_ready = 1'b1; imem1_rsp_valid = 1'b0; imem1_rsp_data = '0;
    redirect1_valid = 1'b0; redirect1_pc = '0;
    pend1_v = 1'b0; pend1_a = '0;
    s_req_ready = 1'b1; s_id_ready = 1'b1; s_redir = 1'b0; s_rpc = '0;
    #1;
    rst_n = 1'b0; rst1_n = 1'b0;
    @(posedge clk);
    #1;

    // 1: streaming, 1-cycle imem, decode always ready
    reset_dut0(1);
    repeat (12) cycle();
    check("s1_fire0", getq(fire_log, 0), 32'h0);
    check("s1_fire1", getq(fire_log, 1), 32'h4);
    check("s1_fire2", getq(fire_log, 2), 32'h8);
    check("s1_fire0_cyc", getq(fire_cyc, 0), 32'd1);
    check("s1_first_valid_cyc", 32'(first_valid_cyc), 32'd3);
    check("s1_pc4_0", getq(dlv_pc4, 0), 32'h4);
    check("s1_pc4_1", getq(dlv_pc4, 1), 32'h8);
    check("s1_pc4_2", getq(dlv_pc4, 2), 32'hC);
    check("s1_instr0", getq(dlv_instr, 0), 32'hC0DE_0000);

    // 2: decode stalled for 10 cycles, then released
    reset_dut0(1);
    s_id_ready = 1'b0;
    repeat (10) cycle();
    check("s2_fires_while_stalled", 32'(fire_log.size()), 32'd2);
    s_id_ready = 1'b1;
    repeat (10) cycle();
    check("s2_pc4_0", getq(dlv_pc4, 0), 32'h4);
    check("s2_pc4_1", getq(dlv_pc4, 1), 32'h8);
    check("s2_pc4_2", getq(dlv_pc4, 2), 32'hC);

    // 3: imem not ready for cycles 4..6 while address 0x8 is requested
    reset_dut0(1);
    for (int i = 0; i < 12; i++) begin
      s_req_ready = !(i >= 4 && i <= 6);
      cycle();
    end
    s_req_ready = 1'b1;
    check("s3_held_cnt", 32'(held_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("s3_held_addr", getq(held_log, i), 32'h8);
    check("s3_fire2", getq(fire_log, 2), 32'h8);
    check("s3_fire2_cyc", getq(fire_cyc, 2), 32'd7);

    // 4: redirect to 0x400 with two responses in flight (3-cycle imem)
    reset_dut0(3);
    repeat (3) cycle();
    s_redir = 1'b1; s_rpc = 32'h0000_0400;
    cycle();
    s_redir = 1'b0;
    repeat (10) cycle();
    check("s4_fire_redir", getq(fire_log, 2), 32'h400);
    check("s4_fire_redir_cyc", getq(fire_cyc, 2), 32'd6);
    check("s4_instr0", getq(dlv_instr, 0), 32'hC0DE_0400);
    check("s4_pc4_0", getq(dlv_pc4, 0), 32'h404);

    // 5: redirect coinciding with a response and a decode pop (2-cycle imem)
    reset_dut0(2);
    repeat (4) cycle();
    s_redir = 1'b1; s_rpc = 32'h0000_0403;
    cycle();
    s_redir = 1'b0;
    check("s5_queue_empty", 32'(id_valid), 32'd0);
    repeat (8) cycle();
    check("s5_fire_redir", getq(fire_log, 2), 32'h400);
    check("s5_fire_redir_cyc", getq(fire_cyc, 2), 32'd5);
    check("s5_pc4_1", getq(dlv_pc4, 1), 32'h404);
    check("s5_instr1", getq(dlv_instr, 1), 32'hC0DE_0400);

    // 6: dut1 with RESET_PC near the top of the address space
    chk0   = 1'b0;
    rst_n  = 1'b0;
    pend_q.delete();
    imem_rsp_valid = 1'b0;
    #1;
    check_dut1_reset("d1_rst");
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    cyc    = 0;
    repeat (8) cycle();
    check("d1_fire0", getq(fire1_log, 0), 32'hFFFF_FFF8);
    check("d1_fire1", getq(fire1_log, 1), 32'hFFFF_FFFC);
    check("d1_fire2", getq(fire1_log, 2), 32'h0000_0000);
    check("d1_pc4_0", getq(dlv1_pc4, 0), 32'hFFFF_FFFC);
    check("d1_pc4_1", getq(dlv1_pc4, 1), 32'h0000_0000);
    check("d1_instr1", getq(dlv1_instr, 1), 32'h3F21_FFFC);

    // mid-stream reset pulse, asserted away from any clock edge
    #2;
    rst1_n = 1'b0;
    pend1_v = 1'b0;
    imem1_rsp_valid = 1'b0;
    #1;
    check_dut1_reset("d1_pulse");
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    fire1_log.delete();
    cyc = 0;
    repeat (4) cycle();
    check("d1_restart_fire0", getq(fire1_log, 0), 32'hFFFF_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
